// File: rtl/count_tracker.sv
// Receive-side tracker for a mod-MODULUS up/down count stream: recovers direction,
// flags steps, wraps, holds and illegal transitions, and keeps a saturating error tally.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | no trusted previous sample; waiting for an in-range value
// S_ACQ    | previous sample known; counting same-direction steps to lock
// S_LOCKED | LOCK_CNT clean steps seen; reversals allowed, errors drop lock
module count_tracker #(
   parameter int MODULUS  = 13,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             sample_en_i,
   input  logic [3:0]       count_in_i,
   input  logic             clr_err_i,
   output logic             dir_o,
   output logic             dir_valid_o,
   output logic             locked_o,
   output logic             step_o,
   output logic             wrap_o,
   output logic             hold_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACQ    = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [4:0]       MOD5     = 5'(MODULUS);
   localparam logic [4:0]       MAX5     = 5'(MODULUS - 1);
   localparam logic [3:0]       LOCK4    = 4'(LOCK_CNT);
   localparam logic [ERR_W-1:0] ERR_SAT  = '1;

   state_t           state_q, state_d;
   logic [3:0]       prev_q, prev_d;
   logic             prev_ok_q, prev_ok_d;
   logic [3:0]       run_q, run_d;
   logic             dir_q, dir_d;
   logic             dir_valid_q, dir_valid_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;
   logic             hold_q, hold_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Classification against the previous sample, widened so MODULUS = 16 compares cleanly
   logic [4:0] s5, p5;
   logic       range_err, up_lin, up_wrap, dn_lin, dn_wrap;
   logic       is_up, is_dn, is_step, is_hold, wrap_ev;
   logic [3:0] run_nx;
   logic       err_ev;

   always_comb begin
      s5        = {1'b0, count_in_i};
      p5        = {1'b0, prev_q};
      range_err = (s5 >= MOD5);
      up_lin    = (p5 != MAX5) && (s5 == p5 + 5'd1);
      up_wrap   = (p5 == MAX5) && (s5 == 5'd0);
      dn_lin    = (p5 != 5'd0) && (s5 == p5 - 5'd1);
      dn_wrap   = (p5 == 5'd0) && (s5 == MAX5);
      is_up     = up_lin | up_wrap;
      is_dn     = ~is_up & (dn_lin | dn_wrap);
      is_step   = is_up | is_dn;
      is_hold   = (s5 == p5);
      wrap_ev   = up_wrap | (is_dn & dn_wrap);
      // First step after resync or same direction extends the run; a reversal restarts it
      if (!dir_valid_q || (is_up == dir_q)) begin
         run_nx = run_q + 4'd1;
      end else begin
         run_nx = 4'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      prev_ok_d   = prev_ok_q;
      run_d       = run_q;
      dir_d       = dir_q;
      dir_valid_d = dir_valid_q;
      step_d      = 1'b0;
      wrap_d      = 1'b0;
      hold_d      = 1'b0;
      err_ev      = 1'b0;

      if (sample_en_i) begin
         if (range_err) begin
            err_ev = 1'b1;
            if (state_q != S_IDLE) begin
               state_d     = S_IDLE;
               prev_ok_d   = 1'b0;
               run_d       = 4'd0;
               dir_valid_d = 1'b0;
            end
         end else if (!prev_ok_q || state_q == S_IDLE) begin
            prev_d    = count_in_i;
            prev_ok_d = 1'b1;
            run_d     = 4'd0;
            state_d   = S_ACQ;
         end else begin
            prev_d = count_in_i;
            if (is_step) begin
               step_d      = 1'b1;
               wrap_d      = wrap_ev;
               dir_d       = is_up;
               dir_valid_d = 1'b1;
               if (state_q == S_ACQ) begin
                  run_d = run_nx;
                  if (run_nx >= LOCK4) begin
                     state_d = S_LOCKED;
                  end
               end
            end else if (is_hold) begin
               hold_d = 1'b1;
            end else begin
               err_ev      = 1'b1;
               run_d       = 4'd0;
               dir_valid_d = 1'b0;
               state_d     = S_ACQ;
            end
         end
      end

      err_d = err_ev;
      if (err_ev) begin
         if (clr_err_i) begin
            err_cnt_d = {{(ERR_W-1){1'b0}}, 1'b1};
         end else if (err_cnt_q == ERR_SAT) begin
            err_cnt_d = err_cnt_q;
         end else begin
            err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
         end
      end else if (clr_err_i) begin
         err_cnt_d = '0;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         prev_q      <= 4'd0;
         prev_ok_q   <= 1'b0;
         run_q       <= 4'd0;
         dir_q       <= 1'b0;
         dir_valid_q <= 1'b0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
         hold_q      <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         prev_ok_q   <= prev_ok_d;
         run_q       <= run_d;
         dir_q       <= dir_d;
         dir_valid_q <= dir_valid_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
         hold_q      <= hold_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign dir_o       = dir_q;
   assign dir_valid_o = dir_valid_q;
   assign locked_o    = (state_q == S_LOCKED);
   assign step_o      = step_q;
   assign wrap_o      = wrap_q;
   assign hold_o      = hold_q;
   assign err_o       = err_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_count_tracker.sv
// Directed bench for count_tracker (MODULUS 13, LOCK_CNT 3, ERR_W 8): table of
// per-sample vectors plus hand sequences for error-tally saturation and clearing.
module tb_count_tracker;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       sample_en_i;
   logic [3:0] count_in_i;
   logic       clr_err_i;
   logic       dir_o, dir_valid_o, locked_o, step_o, wrap_o, hold_o, err_o;
   logic [7:0] err_cnt_o;

   count_tracker #(.MODULUS(13), .LOCK_CNT(3), .ERR_W(8)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .sample_en_i (sample_en_i),
      .count_in_i  (count_in_i),
      .clr_err_i   (clr_err_i),
      .dir_o       (dir_o),
      .dir_valid_o (dir_valid_o),
      .locked_o    (locked_o),
      .step_o      (step_o),
      .wrap_o      (wrap_o),
      .hold_o      (hold_o),
      .err_o       (err_o),
      .err_cnt_o   (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // exp packs {dir, dir_valid, locked, step, wrap, hold, err}
   typedef struct {
      string      name;
      logic       rst_n;
      logic       en;
      logic [3:0] cnt;
      logic       clr;
      logic [6:0] exp;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input string nm, input logic rn, input logic en, input logic [3:0] c,
                      input logic cl, input logic [6:0] e, input logic [7:0] ec);
      vec_t v;
      v.name = nm; v.rst_n = rn; v.en = en; v.cnt = c; v.clr = cl; v.exp = e; v.exp_cnt = ec;
      vecs.push_back(v);
   endtask

   task automatic apply(input logic rn, input logic en, input logic [3:0] c, input logic cl);
      @(negedge clk_i);
      rst_n_i     = rn;
      sample_en_i = en;
      count_in_i  = c;
      clr_err_i   = cl;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string nm, input logic [6:0] e, input logic [7:0] ec);
      logic [6:0] act;
      act = {dir_o, dir_valid_o, locked_o, step_o, wrap_o, hold_o, err_o};
      n_checks++;
      if (act !== e || err_cnt_o !== ec) begin
         n_fail++;
         $display("FAIL %s: got flags(dir,dv,lk,stp,wrp,hld,err)=%b cnt=%0d, expected %b cnt=%0d",
                  nm, act, err_cnt_o, e, ec);
      end
   endtask

   initial begin
      rst_n_i = 1'b0; sample_en_i = 1'b0; count_in_i = 4'd0; clr_err_i = 1'b0;

      //   name           rst  en  cnt  clr   dir dv lk st wr hd er    cnt
      add("reset",        0, 0, 4'd0,  0, 7'b0_0_0_0_0_0_0, 8'd0);
      add("load11",       1, 1, 4'd11, 0, 7'b0_0_0_0_0_0_0, 8'd0);
      add("up12",         1, 1, 4'd12, 0, 7'b1_1_0_1_0_0_0, 8'd0);
      add("up0_wrap",     1, 1, 4'd0,  0, 7'b1_1_0_1_1_0_0, 8'd0);
      add("up1_lock",     1, 1, 4'd1,  0, 7'b1_1_1_1_0_0_0, 8'd0);
      add("dn0_locked",   1, 1, 4'd0,  0, 7'b0_1_1_1_0_0_0, 8'd0);
      add("dn12_wrap",    1, 1, 4'd12, 0, 7'b0_1_1_1_1_0_0, 8'd0);
      add("idle_en0",     1, 0, 4'd5,  0, 7'b0_1_1_0_0_0_0, 8'd0);
      add("up0_wrap2",    1, 1, 4'd0,  0, 7'b1_1_1_1_1_0_0, 8'd0);
      add("up1",          1, 1, 4'd1,  0, 7'b1_1_1_1_0_0_0, 8'd0);
      add("jump5_err",    1, 1, 4'd5,  0, 7'b1_0_0_0_0_0_1, 8'd1);
      add("up6",          1, 1, 4'd6,  0, 7'b1_1_0_1_0_0_0, 8'd1);
      add("up7",          1, 1, 4'd7,  0, 7'b1_1_0_1_0_0_0, 8'd1);
      add("up8_relock",   1, 1, 4'd8,  0, 7'b1_1_1_1_0_0_0, 8'd1);
      add("range14",      1, 1, 4'd14, 0, 7'b1_0_0_0_0_0_1, 8'd2);
      add("idle_load3",   1, 1, 4'd3,  0, 7'b1_0_0_0_0_0_0, 8'd2);
      add("up4_first",    1, 1, 4'd4,  0, 7'b1_1_0_1_0_0_0, 8'd2);
      add("dn3_reverse",  1, 1, 4'd3,  0, 7'b0_1_0_1_0_0_0, 8'd2);
      add("jump7_err",    1, 1, 4'd7,  0, 7'b0_0_0_0_0_0_1, 8'd3);
      add("hold7a",       1, 1, 4'd7,  0, 7'b0_0_0_0_0_1_0, 8'd3);
      add("hold7b",       1, 1, 4'd7,  0, 7'b0_0_0_0_0_1_0, 8'd3);
      add("up8_run1",     1, 1, 4'd8,  0, 7'b1_1_0_1_0_0_0, 8'd3);
      add("up9_run2",     1, 1, 4'd9,  0, 7'b1_1_0_1_0_0_0, 8'd3);
      add("hold9",        1, 1, 4'd9,  0, 7'b1_1_0_0_0_1_0, 8'd3);
      add("up10_lock",    1, 1, 4'd10, 0, 7'b1_1_1_1_0_0_0, 8'd3);
      add("hold10_lock",  1, 1, 4'd10, 0, 7'b1_1_1_0_0_1_0, 8'd3);
      add("clr_only",     1, 0, 4'd10, 1, 7'b1_1_1_0_0_0_0, 8'd0);
      add("rst_override", 0, 1, 4'd11, 1, 7'b0_0_0_0_0_0_0, 8'd0);
      add("acq_load7",    1, 1, 4'd7,  0, 7'b0_0_0_0_0_0_0, 8'd0);
      add("acq_hold7a",   1, 1, 4'd7,  0, 7'b0_0_0_0_0_1_0, 8'd0);
      add("acq_hold7b",   1, 1, 4'd7,  0, 7'b0_0_0_0_0_1_0, 8'd0);
      add("rst_midseq",   0, 1, 4'd8,  0, 7'b0_0_0_0_0_0_0, 8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst_n, vecs[i].en, vecs[i].cnt, vecs[i].clr);
         check(vecs[i].name, vecs[i].exp, vecs[i].exp_cnt);
      end

      // Out-of-range stream in IDLE: tally climbs one per sample then sticks at 255
      begin
         int exp_c;
         exp_c = 0;
         for (int k = 0; k < 300; k++) begin
            apply(1'b1, 1'b1, 4'd15, 1'b0);
            exp_c = (exp_c < 255) ? exp_c + 1 : 255;
            check("sat_stream", 7'b0_0_0_0_0_0_1, 8'(exp_c));
         end
      end
      apply(1'b1, 1'b1, 4'd13, 1'b1);
      check("clr_with_err", 7'b0_0_0_0_0_0_1, 8'd1);
      apply(1'b1, 1'b0, 4'd13, 1'b1);
      check("clr_no_err", 7'b0_0_0_0_0_0_0, 8'd0);

      // IDLE does not classify: after a load, a non-adjacent value is an error, not a load
      apply(1'b1, 1'b1, 4'd2, 1'b0);
      check("idle_load2", 7'b0_0_0_0_0_0_0, 8'd0);
      apply(1'b1, 1'b1, 4'd12, 1'b0);
      check("acq_jump12", 7'b0_0_0_0_0_0_1, 8'd1);
      apply(1'b1, 1'b1, 4'd11, 1'b0);
      check("dn11_first", 7'b0_1_0_1_0_0_0, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
